// File: rtl/egress_fifo_bank_pkg.sv
// Shared constants for the egress FIFO bank: word width, lane count,
// the init state encoding and the destination field position.
package egress_pkg;

  localparam int        WORD_W     = 10;
  localparam int        LANES      = 4;
  localparam logic [3:0] STATE_INIT = 4'b0001;

  // Destination field inside a word; carried through the FIFOs untouched.
  localparam int DEST_HI = 9;
  localparam int DEST_LO = 8;

endpackage

// File: rtl/egress_fifo_bank_lane_fifo.sv
// Single-lane FIFO: nonzero words are pushed, pops return the head word
// registered one cycle later as a single-cycle pulse. Occupancy is tracked
// by an explicit count so full and empty never depend on pointer equality.
module lane_fifo #(
  parameter int WORD_W      = egress_pkg::WORD_W,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              ovf,
  output logic              udf,
  output logic              drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic push_req;
  logic push_ok;
  logic pop_ok;

  // A zero word is idle and never a push; flush masks all requests.
  assign push_req = !flush && (|din);
  assign push_ok  = push_req && !full;
  assign pop_ok   = !flush && pop && !empty;
  // A push into a full lane is lost even if a pop frees a slot this cycle.
  assign drop     = push_req && full;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (count >= CNT_W'(ALMOST_FULL));

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy, output pulse and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      dout  <= pop_ok ? mem[rd_ptr] : '0;
      if (drop)          ovf <= 1'b1;
      if (pop && empty)  udf <= 1'b1;
    end
  end

endmodule

// File: rtl/egress_fifo_bank.sv
// Egress FIFO bank: one lane_fifo per routed mux output lane, with a
// shared init flush. Optional macro DROP_CNT_EN adds DropCount, a
// saturating total of pushes rejected across all lanes.
module egress_fifo_bank #(
  parameter int WORD_W      = egress_pkg::WORD_W,
  parameter int DEPTH       = 4,
  parameter int ALMOST_FULL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic [WORD_W-1:0] In0,
  input  logic [WORD_W-1:0] In1,
  input  logic [WORD_W-1:0] In2,
  input  logic [WORD_W-1:0] In3,
  input  logic              Pop0,
  input  logic              Pop1,
  input  logic              Pop2,
  input  logic              Pop3,
  output logic [WORD_W-1:0] Data0,
  output logic [WORD_W-1:0] Data1,
  output logic [WORD_W-1:0] Data2,
  output logic [WORD_W-1:0] Data3,
  output logic [3:0]        Empty,
  output logic [3:0]        Full,
  output logic [3:0]        AlmostFull,
  output logic [3:0]        Overflow,
  output logic [3:0]        Underflow
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]        DropCount
`endif
);

  import egress_pkg::*;

  logic              flush;
  logic [WORD_W-1:0] din  [LANES];
  logic [WORD_W-1:0] dout [LANES];
  logic [LANES-1:0]  pop;
  logic [LANES-1:0]  drop;

  assign flush = (state == STATE_INIT);

  assign din[0] = In0;
  assign din[1] = In1;
  assign din[2] = In2;
  assign din[3] = In3;
  assign pop    = {Pop3, Pop2, Pop1, Pop0};

  assign Data0 = dout[0];
  assign Data1 = dout[1];
  assign Data2 = dout[2];
  assign Data3 = dout[3];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_fifo #(
      .WORD_W      (WORD_W),
      .DEPTH       (DEPTH),
      .ALMOST_FULL (ALMOST_FULL)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .din         (din[i]),
      .pop         (pop[i]),
      .dout        (dout[i]),
      .empty       (Empty[i]),
      .full        (Full[i]),
      .almost_full (AlmostFull[i]),
      .ovf         (Overflow[i]),
      .udf         (Underflow[i]),
      .drop        (drop[i])
    );
  end

`ifdef DROP_CNT_EN
  localparam int SUM_W = $clog2(LANES + 1);

  // Add this cycle's drops, clamping at the all-ones value.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [SUM_W-1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [SUM_W-1:0] drop_sum;

  // Number of lanes rejecting a push this cycle.
  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < LANES; i++) drop_sum = drop_sum + SUM_W'(drop[i]);
  end

  // Saturating drop total, cleared by reset or init.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      DropCount <= '0;
    else if (flush) DropCount <= '0;
    else            DropCount <= sat_add8(DropCount, drop_sum);
  end
`else
  logic unused_drop;
  assign unused_drop = ^drop;
`endif

endmodule
